// File: rtl/spi_slave_param.sv
// Oversampled SPI slave: pins synchronised into clk, all four modes.
// Ports: clk/rst, SPI pins (sclk, mosi, cs_n, miso, miso_oe), mode,
//   TX valid/ready, RX valid/ready, busy/done and error pulses.
module spi_slave_param #(
  parameter int                DATA_W      = 8,
  parameter bit                LSB_FIRST   = 1'b0,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_FILL   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs_n,
  output logic              miso,
  output logic              miso_oe,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              done,
  output logic              tx_underrun,
  output logic              rx_overrun,
  output logic              frame_err
);

  localparam int CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic sclk_h_q, mosi_h_q, cs_h_q;
  logic sck_rise_q, sck_fall_q;
  logic cs_rise_q, cs_fall_q;
  logic sclk_s, mosi_s, cs_s;

  state_t            state_q, state_d;
  logic [1:0]        fmode_q, fmode_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              full_q, full_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              done_q, done_d;
  logic              und_q, und_d;
  logic              ovr_q, ovr_d;
  logic              ferr_q, ferr_d;

  logic              sample_e, shift_e, load;
  logic [DATA_W-1:0] rx_next;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];

  // Chains reset low: a frame already running when reset is
  // released shows no cs_n fall, so it is skipped until cs_n cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '0;
      sclk_h_q    <= 1'b0;
      mosi_h_q    <= 1'b0;
      cs_h_q      <= 1'b0;
      sck_rise_q  <= 1'b0;
      sck_fall_q  <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_fall_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      sclk_h_q    <= sclk_s;
      mosi_h_q    <= mosi_s;
      cs_h_q      <= cs_s;
      sck_rise_q  <= sclk_s & ~sclk_h_q;
      sck_fall_q  <= ~sclk_s & sclk_h_q;
      cs_rise_q   <= cs_s & ~cs_h_q;
      cs_fall_q   <= ~cs_s & cs_h_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fmode_q    <= 2'b00;
      tx_sr_q    <= '0;
      tx_cnt_q   <= '0;
      rx_sr_q    <= '0;
      rx_cnt_q   <= '0;
      hold_q     <= '0;
      full_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      und_q      <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fmode_q    <= fmode_d;
      tx_sr_q    <= tx_sr_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_sr_q    <= rx_sr_d;
      rx_cnt_q   <= rx_cnt_d;
      hold_q     <= hold_d;
      full_q     <= full_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      done_q     <= done_d;
      und_q      <= und_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fmode_d    = fmode_q;
    tx_sr_d    = tx_sr_q;
    tx_cnt_d   = tx_cnt_q;
    rx_sr_d    = rx_sr_q;
    rx_cnt_d   = rx_cnt_q;
    hold_d     = hold_q;
    full_d     = full_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    done_d     = 1'b0;
    und_d      = 1'b0;
    ovr_d      = 1'b0;
    ferr_d     = 1'b0;
    load       = 1'b0;

    // Modes 0/3 sample on rising sclk, modes 1/2 on falling.
    sample_e = (fmode_q[1] == fmode_q[0]) ? sck_rise_q : sck_fall_q;
    shift_e  = (fmode_q[1] == fmode_q[0]) ? sck_fall_q : sck_rise_q;

    if (LSB_FIRST) begin
      rx_next = {mosi_h_q, rx_sr_q[DATA_W-1:1]};
    end else begin
      rx_next = {rx_sr_q[DATA_W-2:0], mosi_h_q};
    end

    if (tx_valid && !full_q) begin
      hold_d = tx_data;
      full_d = 1'b1;
    end

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (cs_fall_q) begin
          state_d  = ACTIVE;
          fmode_d  = mode;
          tx_cnt_d = '0;
          rx_cnt_d = '0;
          rx_sr_d  = '0;
          load     = ~mode[0];
        end
      end
      ACTIVE: begin
        if (sample_e) begin
          rx_sr_d = rx_next;
          if (rx_cnt_q == LAST) begin
            rx_cnt_d = '0;
            if (!rx_valid_q || rx_ready) begin
              rx_data_d  = rx_next;
              rx_valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            rx_cnt_d = rx_cnt_q + CW'(1);
          end
        end
        if (shift_e) begin
          // CPHA=0 refills after a word's last bit, CPHA=1 before its first.
          if (tx_cnt_q == (fmode_q[0] ? '0 : LAST)) begin
            load = 1'b1;
          end else if (LSB_FIRST) begin
            tx_sr_d = tx_sr_q >> 1;
          end else begin
            tx_sr_d = tx_sr_q << 1;
          end
          tx_cnt_d = (tx_cnt_q == LAST) ? '0 : tx_cnt_q + CW'(1);
        end
        // A same-cycle sample edge has already been folded in above.
        if (cs_rise_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
          ferr_d  = (rx_cnt_d != '0);
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      if (full_q) begin
        tx_sr_d = hold_q;
        full_d  = 1'b0;
      end else begin
        tx_sr_d = IDLE_FILL;
        und_d   = 1'b1;
      end
    end
  end

  assign busy        = (state_q == ACTIVE);
  assign miso_oe     = busy;
  assign miso        = busy &
                       (LSB_FIRST ? tx_sr_q[0] : tx_sr_q[DATA_W-1]);
  assign tx_ready    = ~full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign done        = done_q;
  assign tx_underrun = und_q;
  assign rx_overrun  = ovr_q;
  assign frame_err   = ferr_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: an 8-bit MSB-first instance and a
// 16-bit LSB-first instance driven by a behavioural SPI master.
module tb_spi_slave_param;

  localparam int H = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        cs_a = 1'b1;
  logic        cs_b = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic        sel = 1'b0;
  logic [15:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        rx_ready = 1'b1;

  logic [7:0]  rx_data_a;
  logic [15:0] rx_data_b;
  logic miso_a, oe_a, txr_a, rxv_a, busy_a;
  logic done_a, und_a, ovr_a, ferr_a;
  logic miso_b, oe_b, txr_b, rxv_b, busy_b;
  logic done_b, und_b, ovr_b, ferr_b;

  spi_slave_param #(
    .DATA_W(8), .LSB_FIRST(1'b0),
    .SYNC_STAGES(2), .IDLE_FILL(8'hFF)
  ) dut_a (
    .clk(clk), .rst(rst),
    .sclk(sclk), .mosi(mosi), .cs_n(cs_a),
    .miso(miso_a), .miso_oe(oe_a), .mode(mode),
    .tx_data(tx_data[7:0]),
    .tx_valid(tx_valid & ~sel), .tx_ready(txr_a),
    .rx_data(rx_data_a), .rx_valid(rxv_a),
    .rx_ready(rx_ready), .busy(busy_a), .done(done_a),
    .tx_underrun(und_a), .rx_overrun(ovr_a),
    .frame_err(ferr_a)
  );

  spi_slave_param #(
    .DATA_W(16), .LSB_FIRST(1'b1),
    .SYNC_STAGES(2), .IDLE_FILL(16'h0000)
  ) dut_b (
    .clk(clk), .rst(rst),
    .sclk(sclk), .mosi(mosi), .cs_n(cs_b),
    .miso(miso_b), .miso_oe(oe_b), .mode(mode),
    .tx_data(tx_data),
    .tx_valid(tx_valid & sel), .tx_ready(txr_b),
    .rx_data(rx_data_b), .rx_valid(rxv_b),
    .rx_ready(rx_ready), .busy(busy_b), .done(done_b),
    .tx_underrun(und_b), .rx_overrun(ovr_b),
    .frame_err(ferr_b)
  );

  wire        miso_s = sel ? miso_b : miso_a;
  wire        oe_s   = sel ? oe_b : oe_a;
  wire        busy_s = sel ? busy_b : busy_a;
  wire        txr_s  = sel ? txr_b : txr_a;
  wire        rxv_s  = sel ? rxv_b : rxv_a;
  wire [15:0] rxd_s  = sel ? rx_data_b : {8'h00, rx_data_a};
  wire        done_s = sel ? done_b : done_a;
  wire        und_s  = sel ? und_b : und_a;
  wire        ovr_s  = sel ? ovr_b : ovr_a;
  wire        ferr_s = sel ? ferr_b : ferr_a;

  int checks = 0;
  int errors = 0;
  int n_done = 0, n_und = 0, n_ovr = 0, n_ferr = 0;

  logic [15:0] txq[$];
  logic [15:0] rxq[$];
  logic [15:0] mo[4];
  logic [15:0] mi[4];
  logic [15:0] ex[4];
  logic        rdy_seen = 1'b0;
  logic        v_prev = 1'b0;

  always @(negedge clk) begin
    if (done_s) n_done++;
    if (und_s)  n_und++;
    if (ovr_s)  n_ovr++;
    if (ferr_s) n_ferr++;
    if (rxv_s && !v_prev) rxq.push_back(rxd_s);
    v_prev = rxv_s;
  end

  // Offers queued words whenever the holding register is empty.
  always @(negedge clk) begin
    if (!rst) begin
      tx_valid = 1'b0;
      rdy_seen = 1'b0;
    end else begin
      if (tx_valid && rdy_seen) begin
        void'(txq.pop_front());
        tx_valid = 1'b0;
      end
      rdy_seen = txr_s;
      if (!tx_valid && rdy_seen && txq.size() > 0) begin
        tx_data  = txq[0];
        tx_valid = 1'b1;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic begin_test(input logic s);
    @(negedge clk);
    rst = 1'b0;
    sel = s;
    cs_a = 1'b1;
    cs_b = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    rx_ready = 1'b1;
    txq.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic release_rst();
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic set_cs(input logic v);
    if (sel) cs_b = v;
    else cs_a = v;
  endtask

  // Master: nbits bits of words mo[], w bits per word; miso into mi[].
  task automatic frame(input logic [1:0] md, input int nbits,
                       input int w, input logic lsb,
                       input logic glitch, input logic fin);
    int wi, bi;
    for (int i = 0; i < 4; i++) mi[i] = '0;
    mode = md;
    sclk = md[1];
    repeat (H) @(negedge clk);
    set_cs(1'b0);
    repeat (H) @(negedge clk);
    for (int k = 0; k < nbits; k++) begin
      wi = k / w;
      bi = lsb ? (k % w) : (w - 1 - (k % w));
      if (!md[0]) begin
        mosi = mo[wi][bi];
        repeat (H) @(negedge clk);
        mi[wi][bi] = miso_s;
        sclk = ~sclk;
        repeat (H) @(negedge clk);
        sclk = ~sclk;
      end else begin
        sclk = ~sclk;
        mosi = mo[wi][bi];
        repeat (H) @(negedge clk);
        mi[wi][bi] = miso_s;
        sclk = ~sclk;
        repeat (H) @(negedge clk);
      end
      if (glitch && k == 0) mode = ~md;
    end
    if (fin) begin
      repeat (H) @(negedge clk);
      set_cs(1'b1);
      repeat (2 * H) @(negedge clk);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_miso"}, miso_s, 1'b0);
    chk({tag, "_oe"}, oe_s, 1'b0);
    chk({tag, "_busy"}, busy_s, 1'b0);
    chk({tag, "_txready"}, txr_s, 1'b1);
    chk({tag, "_rxvalid"}, rxv_s, 1'b0);
    chk({tag, "_rxdata"}, rxd_s, 16'h0);
    chk({tag, "_pulses"},
        {done_s, und_s, ovr_s, ferr_s}, 4'b0);
  endtask

  function automatic logic [15:0] rx_at(input int idx);
    return (rxq.size() > idx) ? rxq[idx] : 16'hxxxx;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int d_done, d_und, d_ovr, d_ferr, base;
    int md, nw, ld, q;
    logic [1:0] m2;

    begin_test(1'b0);
    chk_reset("rst_in");
    release_rst();
    chk_reset("rst_out");

    // Mode 0 single word, rx held until accepted
    begin_test(1'b0);
    txq = '{16'h00A5, 16'h005A};
    release_rst();
    rx_ready = 1'b0;
    mo[0] = 16'h003C;
    d_done = n_done; d_und = n_und; base = rxq.size();
    frame(2'b00, 8, 8, 1'b0, 1'b0, 1'b1);
    chk("m0_miso", mi[0][7:0], 8'hA5);
    chk("m0_rxvalid", rxv_s, 1'b1);
    chk("m0_rxdata", rxd_s, 16'h003C);
    repeat (20) @(negedge clk);
    chk("m0_rxheld", rxv_s, 1'b1);
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("m0_rxclr", rxv_s, 1'b0);
    chk("m0_done", n_done - d_done, 1);
    chk("m0_und", n_und - d_und, 0);
    chk("m0_rxq", rx_at(base), 16'h003C);

    // Modes 1..3, 3-word bursts, mode pin changed mid-frame
    for (int m = 1; m < 4; m++) begin
      begin_test(1'b0);
      txq = '{16'h11, 16'h22, 16'h33};
      if (m == 2) txq.push_back(16'h44);
      release_rst();
      mo[0] = 16'hF0; mo[1] = 16'h0F; mo[2] = 16'hAA;
      d_done = n_done; d_und = n_und; d_ferr = n_ferr;
      base = rxq.size();
      frame(2'(m), 24, 8, 1'b0, 1'b1, 1'b1);
      chk($sformatf("m%0d_miso0", m), mi[0][7:0], 8'h11);
      chk($sformatf("m%0d_miso1", m), mi[1][7:0], 8'h22);
      chk($sformatf("m%0d_miso2", m), mi[2][7:0], 8'h33);
      chk($sformatf("m%0d_rx0", m), rx_at(base), 16'hF0);
      chk($sformatf("m%0d_rx1", m), rx_at(base + 1), 16'h0F);
      chk($sformatf("m%0d_rx2", m), rx_at(base + 2), 16'hAA);
      chk($sformatf("m%0d_und", m), n_und - d_und, 0);
      chk($sformatf("m%0d_done", m), n_done - d_done, 1);
      chk($sformatf("m%0d_ferr", m), n_ferr - d_ferr, 0);
    end

    // Random frames: words fetched in order, fill once queue empties
    for (int it = 0; it < 6; it++) begin
      md = $urandom_range(0, 3);
      m2 = 2'(md);
      nw = $urandom_range(1, 3);
      ld = nw + (m2[0] ? 0 : 1);
      q = $urandom_range(0, ld);
      begin_test(1'b0);
      for (int i = 0; i < q; i++) begin
        ex[i] = {8'h00, 8'($urandom)};
        txq.push_back(ex[i]);
      end
      for (int i = 0; i < nw; i++) mo[i] = {8'h00, 8'($urandom)};
      release_rst();
      d_done = n_done; d_und = n_und; base = rxq.size();
      frame(m2, nw * 8, 8, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < nw; i++) begin
        chk($sformatf("rnd%0d_miso%0d", it, i), mi[i][7:0],
            (i < q) ? ex[i][7:0] : 8'hFF);
        chk($sformatf("rnd%0d_rx%0d", it, i), rx_at(base + i),
            mo[i]);
      end
      chk($sformatf("rnd%0d_und", it), n_und - d_und, ld - q);
      chk($sformatf("rnd%0d_done", it), n_done - d_done, 1);
    end

    // 16-bit LSB-first instance
    begin_test(1'b1);
    txq = '{16'hBEEF, 16'h0000};
    release_rst();
    mo[0] = 16'h1234;
    d_und = n_und; base = rxq.size();
    frame(2'b00, 16, 16, 1'b1, 1'b0, 1'b1);
    chk("lsb_miso", mi[0], 16'hBEEF);
    chk("lsb_rx", rx_at(base), 16'h1234);
    chk("lsb_und", n_und - d_und, 0);

    // Underrun: nothing offered, mode 1, two words
    begin_test(1'b0);
    release_rst();
    mo[0] = 16'hC3; mo[1] = 16'h3C;
    d_und = n_und; base = rxq.size();
    frame(2'b01, 16, 8, 1'b0, 1'b0, 1'b1);
    chk("und_miso0", mi[0][7:0], 8'hFF);
    chk("und_miso1", mi[1][7:0], 8'hFF);
    chk("und_cnt", n_und - d_und, 2);
    chk("und_rx1", rx_at(base + 1), 16'h3C);

    // Overrun: consumer stalled across two words
    begin_test(1'b0);
    txq = '{16'h0, 16'h0, 16'h0};
    release_rst();
    rx_ready = 1'b0;
    mo[0] = 16'h01; mo[1] = 16'h02;
    d_ovr = n_ovr;
    frame(2'b00, 16, 8, 1'b0, 1'b0, 1'b1);
    chk("ovr_rxdata", rxd_s, 16'h0001);
    chk("ovr_rxvalid", rxv_s, 1'b1);
    chk("ovr_cnt", n_ovr - d_ovr, 1);

    // Framing error after 5 bits
    begin_test(1'b0);
    txq = '{16'h0, 16'h0};
    release_rst();
    rx_ready = 1'b0;
    mo[0] = 16'h77;
    frame(2'b00, 8, 8, 1'b0, 1'b0, 1'b1);
    chk("fe_pre_data", rxd_s, 16'h0077);
    d_done = n_done; d_ferr = n_ferr;
    mo[0] = 16'hE5;
    frame(2'b00, 5, 8, 1'b0, 1'b0, 1'b1);
    chk("fe_ferr", n_ferr - d_ferr, 1);
    chk("fe_done", n_done - d_done, 1);
    chk("fe_rxvalid", rxv_s, 1'b1);
    chk("fe_rxdata", rxd_s, 16'h0077);

    // Reset mid-frame, then the running frame is ignored
    begin_test(1'b0);
    txq = '{16'h96, 16'h00};
    release_rst();
    mo[0] = 16'hE1;
    frame(2'b00, 3, 8, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("midrst");
    txq.delete();
    txq = '{16'h69, 16'h00};
    rst = 1'b1;
    d_done = n_done; d_ferr = n_ferr;
    for (int i = 0; i < 10; i++) begin
      repeat (H) @(negedge clk);
      sclk = ~sclk;
    end
    repeat (H) @(negedge clk);
    chk("midrst_busy", busy_s, 1'b0);
    cs_a = 1'b1;
    repeat (2 * H) @(negedge clk);
    chk("midrst_done", n_done - d_done, 0);
    chk("midrst_ferr", n_ferr - d_ferr, 0);
    mo[0] = 16'h5A;
    base = rxq.size();
    frame(2'b00, 8, 8, 1'b0, 1'b0, 1'b1);
    chk("post_miso", mi[0][7:0], 8'h69);
    chk("post_rx", rx_at(base), 16'h5A);
    chk("post_done", n_done - d_done, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_param.md
# spi_slave_param

Parametrised, fully oversampled SPI slave for the FPGA side of the master link. SCLK, MOSI and CS_n are synchronised into the system clock domain and edge-detected, so no logic is clocked by SCLK. Word width, bit order and fill value are configurable, and all four SPI modes are supported. Valid/ready handshakes with single-entry holding registers, plus underrun, overrun and framing flags, connect it to the upstream register/command logic.

## Interface
- DATA_W, 8: bits per SPI word (≥2)
- LSB_FIRST, 0: 0 = MSB first, 1 = LSB first, both directions
- SYNC_STAGES, 2: synchroniser flops on sclk/mosi/cs_n (≥2)
- IDLE_FILL, 0: DATA_W-bit word shifted out on TX underrun
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- sclk, mosi, cs_n  in  1 each  SPI pins (asynchronous)
- miso  out  1  SPI data out
- miso_oe  out  1  pad output enable
- mode  in  2  {CPOL,CPHA}; sampled at frame start
- tx_data  in  DATA_W  next word to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  TX holding register empty
- rx_data  out  DATA_W  received word
- rx_valid  out  1  rx_data valid, held until accepted
- rx_ready  in  1  consumer accepts rx_data
- busy  out  1  frame in progress
- done  out  1  1-clk pulse at frame end
- tx_underrun, rx_overrun, frame_err  out  1 each  1-clk error pulses

## Operation
- Synchronisers: sclk, mosi and cs_n each pass through SYNC_STAGES flops, then one history flop for edge detection. mosi is delayed identically so it stays aligned with sclk.
- Sample edge: rising for modes 0/3, falling for modes 1/2. Shift edge is the opposite edge.
- FSM IDLE → ACTIVE on a synced cs_n falling edge.
  - mode is latched into frame_mode; mid-frame changes are ignored.
  - bit counters clear.
  - CPHA=0: shift register loads immediately.
- FSM ACTIVE → IDLE on a synced cs_n rising edge.
  - done pulses.
  - frame_err pulses if the RX bit count ≠ 0; the partial word is discarded.
- Sclk edges seen in IDLE are ignored.
- TX holding register:
  - tx_ready = empty.
  - tx_valid && tx_ready loads the register and clears tx_ready on the next clk.
- TX shift-register load happens at the word boundary:
  - CPHA=0: at frame start, and at the first shift edge after each DATA_W-th sample edge.
  - CPHA=1: at the first shift edge of each word.
  - The load takes the holding register (which then becomes empty) if full. Otherwise it takes IDLE_FILL and pulses tx_underrun.
  - CPHA=0 fetches a word at the final trailing edge of a frame. That word counts as consumed even if no bits of it are sampled.
- Each subsequent shift edge advances the shift register by one bit.
- miso = current shift-register bit while ACTIVE, 0 in IDLE. miso_oe = busy = (state == ACTIVE).
- RX:
  - Each sample edge shifts synced mosi in, into the LSB end for MSB-first and the MSB end for LSB-first.
  - On the DATA_W-th bit, if rx_valid=0 or rx_ready=1 that cycle: rx_data ← word, rx_valid=1.
  - Otherwise the new word is dropped, rx_overrun pulses, and the old word is kept.
  - rx_valid && rx_ready with no new word clears rx_valid.
- Bit counters are log2(DATA_W) wide and wrap to 0 after DATA_W-1. Words repeat indefinitely within a frame.
- cs_n rising on the same clk as a sample edge: the edge is processed first, then the frame ends. A completed word is still delivered.
- Asynchronous reset is allowed mid-frame. After release the FSM waits in IDLE for the next cs_n falling edge; a frame already in progress is ignored until cs_n rises and falls again.

## Timing
- Reset values:
  - miso 0, miso_oe 0, busy 0
  - tx_ready 1, rx_valid 0, rx_data 0
  - done, tx_underrun, rx_overrun, frame_err all 0
  - FSM IDLE, holding register empty
- Pin-to-internal latency is SYNC_STAGES+1 clk. All registered outputs add 1 clk.
  - rx_valid rises SYNC_STAGES+2 clk after the completing sample edge at the pin.
  - miso changes SYNC_STAGES+2 clk after a shift edge, or after the cs_n fall for the CPHA=0 first bit.
  - done rises SYNC_STAGES+2 clk after cs_n rises.
- Requirement: clk frequency ≥ (2·SYNC_STAGES+6) × f_sclk, i.e. ≥10× for the default. This keeps miso settled before the master's sample edge. The master must leave ≥ SYNC_STAGES+3 clk between the cs_n fall and the first sclk edge.
- tx_ready reasserts 1 clk after a shift-register load consumes the holding register.

## Test plan
- Mode 0, DATA_W=8, tx 0xA5 preloaded, master sends 0x3C → master reads 0xA5; rx_data=0x3C, rx_valid held until rx_ready; done pulses once; tx_underrun=0.
- Modes 1, 2 and 3, each a 3-word burst with tx 0x11,0x22,0x33 fed on tx_ready, master sending 0xF0,0x0F,0xAA → all words correct both directions; changing mode mid-frame has no effect.
- LSB_FIRST=1, DATA_W=16: master sends 0x1234 LSB first → rx_data=0x1234; tx 0xBEEF observed LSB first on miso.
- No tx_valid, IDLE_FILL=0xFF, 2-word frame → miso all ones, two tx_underrun pulses.
- rx_ready held 0 over 2 words 0x01,0x02 → rx_data stays 0x01, one rx_overrun pulse.
- cs_n raised after 5 bits of a word → frame_err and done pulse, rx_valid unchanged. Reset asserted mid-frame → all outputs return to reset values; the next complete frame transfers correctly.
